issue_queue: RTL and testbench
==============================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, number of entries (power of 2, at least 2).
REQ-002 SHALL provide parameter NSRC, default 3, source operands per entry (A, B, store data).
REQ-003 SHALL provide parameter TAG_W, default 6, physical register tag width.
REQ-004 SHALL provide parameter DATA_W, default 32, operand width.
REQ-005 SHALL provide parameter PAYLOAD_W, default 138, opaque decoded-control payload width.
REQ-006 SHALL provide parameter SEQ_W, default 6, instruction sequence number width.
REQ-007 SHALL provide port CLK, in, 1, clock; all state updates on rising edge.
REQ-008 SHALL provide port RESET, in, 1, asynchronous, active-low reset.
REQ-009 SHALL provide port STALL, in, 1, freezes enqueue and issue.
REQ-010 SHALL provide port FLUSH, in, 1, synchronous squash of all entries.
REQ-011 SHALL provide port enq_valid, in, 1, rename presents an instruction.
REQ-012 SHALL provide port enq_ready, out, 1, free slot exists.
REQ-013 SHALL provide port enq_seq, in, SEQ_W, instruction sequence number.
REQ-014 SHALL provide port enq_payload, in, PAYLOAD_W, control bits.
REQ-015 SHALL provide port enq_tag, in, NSRC*TAG_W, source tags; source i is at bits [i*TAG_W +: TAG_W].
REQ-016 SHALL provide port enq_busy, in, NSRC, per-source pending flag (1 = value not yet produced).
REQ-017 SHALL provide port enq_val, in, NSRC*DATA_W, source values, valid where busy = 0.
REQ-018 SHALL provide port bc_valid, in, 1, execution result broadcast.
REQ-019 SHALL provide port bc_tag, in, TAG_W, broadcast destination tag.
REQ-020 SHALL provide port bc_val, in, DATA_W, broadcast result value.
REQ-021 SHALL provide port head_seq, in, SEQ_W, ROB head sequence number (oldest in flight).
REQ-022 SHALL provide port iss_valid, out, 1, issued instruction valid this cycle.
REQ-023 SHALL provide port iss_payload, out, PAYLOAD_W, payload of the issued instruction.
REQ-024 SHALL provide port iss_val, out, NSRC*DATA_W, operand values of the issued instruction.
REQ-025 SHALL provide port iss_seq, out, SEQ_W, sequence number of the issued instruction.
REQ-026 SHALL provide port count, out, $clog2(DEPTH+1), number of occupied entries.

Function
REQ-027 SHALL treat tag 0 as always ready: its busy flag is ignored and its enq_val is used.
REQ-028 SHALL accept an enqueue when enq_valid=1, enq_ready=1, STALL=0 and FLUSH=0, writing the lowest-index free slot.
REQ-029 SHALL drive enq_ready = (count < DEPTH), derived from registered state only; a same-cycle issue does not free a slot for that cycle's enqueue.
REQ-030 SHALL, when bc_valid=1, mark every valid entry's waiting source whose tag equals bc_tag (nonzero) as ready and capture bc_val, including while STALL=1.
REQ-031 SHALL ignore a broadcast for sources that are already ready; their stored value is not overwritten.
REQ-032 SHALL allow an entry to be selected only once all NSRC sources are ready in registered state, so a wakeup is visible for selection the cycle after the broadcast.
REQ-033 SHALL, when STALL=0, register the selected entry onto the iss_* outputs with iss_valid=1 and free that slot on the same edge.
REQ-034 SHALL otherwise drive iss_valid=0 with iss_payload, iss_val and iss_seq zeroed.
REQ-035 SHALL issue at most one entry per cycle.
REQ-036 SHALL leave count unchanged when an enqueue and an issue occur in the same cycle.
REQ-037 SHALL, under STALL=1, hold all iss_* outputs, make no enqueue and no issue, and keep only broadcast wakeup active.
REQ-038 SHALL, under FLUSH=1, on the edge invalidate all entries, clear iss_valid and set count to 0; FLUSH has priority over enqueue, issue and STALL.

Reset
REQ-039 SHALL, while RESET=0, asynchronously clear all entry valid and ready bits, all iss_* outputs and count to 0, with enq_ready=1.
REQ-040 SHALL, when RESET is asserted mid-operation, discard all entries without issuing any of them.

Configuration
REQ-041 SHALL, with macro ISSUE_OLDEST_FIRST_EN defined, select among ready entries the one with the smallest age = (seq - head_seq) mod 2^SEQ_W, breaking ties by lowest index.
REQ-042 SHALL, with ISSUE_OLDEST_FIRST_EN undefined, select the lowest-index ready entry and ignore head_seq.
REQ-043 SHALL, in both configurations, leave enqueue, wakeup, flush and reset behaviour unchanged.

Verification
REQ-044 SHALL cover: enqueue seq=5, tags {0,0,0}, vals {3,4,0} -> iss_valid=1 on the next edge, iss_val={3,4,0}, iss_seq=5, count 1->0.
REQ-045 SHALL cover: enqueue tag A=12 busy, then bc_valid with bc_tag=12, bc_val=0xDEAD -> iss_valid one cycle after the broadcast edge, operand A = 0xDEAD.
REQ-046 SHALL cover: enqueue 16 busy entries -> enq_ready=0, count=16; 17th enq_valid is not accepted; one wakeup and issue -> enq_ready=1 the following cycle.
REQ-047 SHALL cover, with ISSUE_OLDEST_FIRST_EN: head_seq=60, ready entries seq 62 (slot 0) and 1 (slot 1) -> seq 62 issues first; macro undefined -> slot 0 issues first.
REQ-048 SHALL cover: STALL=1 with a broadcast matching a waiting entry -> no issue, iss outputs held; STALL drops -> entry issues with the captured value.
REQ-049 SHALL cover: 8 entries resident, FLUSH=1 for one cycle -> count=0, iss_valid=0, enq_ready=1; RESET pulse mid-stream -> same result asynchronously.

Source files
------------

// File: rtl/issue_queue.sv
// Out-of-order issue queue: holds renamed instructions until all source operands are captured, then issues one.
// Latency: an entry whose sources are all ready at enqueue issues on the edge after the enqueue edge; wakeups add one cycle.
// Backpressure: enq_ready drops when all DEPTH slots are occupied (registered count only); STALL freezes enqueue and issue.
//
// Ports: CLK/RESET (async, active-low), STALL, FLUSH; enq_* rename-side write port with per-source tag/busy/value;
//        bc_* result broadcast for wakeup; head_seq ROB head for age; iss_* registered issue port; count occupancy.
// Build option: define ISSUE_OLDEST_FIRST_EN to select the oldest ready entry relative to head_seq instead of lowest index.
module issue_queue #(
    parameter int DEPTH     = 16,
    parameter int NSRC      = 3,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 138,
    parameter int SEQ_W     = 6
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       STALL,
    input  logic                       FLUSH,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [SEQ_W-1:0]           enq_seq,
    input  logic [PAYLOAD_W-1:0]       enq_payload,
    input  logic [NSRC*TAG_W-1:0]      enq_tag,
    input  logic [NSRC-1:0]            enq_busy,
    input  logic [NSRC*DATA_W-1:0]     enq_val,
    input  logic                       bc_valid,
    input  logic [TAG_W-1:0]           bc_tag,
    input  logic [DATA_W-1:0]          bc_val,
    input  logic [SEQ_W-1:0]           head_seq,
    output logic                       iss_valid,
    output logic [PAYLOAD_W-1:0]       iss_payload,
    output logic [NSRC*DATA_W-1:0]     iss_val,
    output logic [SEQ_W-1:0]           iss_seq,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]          vld_q, vld_d;
    logic [NSRC-1:0]           rdy_q [DEPTH];
    logic [NSRC-1:0]           rdy_d [DEPTH];
    logic [NSRC*TAG_W-1:0]     tag_q [DEPTH];
    logic [NSRC*TAG_W-1:0]     tag_d [DEPTH];
    logic [NSRC*DATA_W-1:0]    val_q [DEPTH];
    logic [NSRC*DATA_W-1:0]    val_d [DEPTH];
    logic [SEQ_W-1:0]          seq_q [DEPTH];
    logic [SEQ_W-1:0]          seq_d [DEPTH];
    logic [PAYLOAD_W-1:0]      pay_q [DEPTH];
    logic [PAYLOAD_W-1:0]      pay_d [DEPTH];
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      iss_valid_q, iss_valid_d;
    logic [PAYLOAD_W-1:0]      iss_payload_q, iss_payload_d;
    logic [NSRC*DATA_W-1:0]    iss_val_q, iss_val_d;
    logic [SEQ_W-1:0]          iss_seq_q, iss_seq_d;

    logic [IDX_W-1:0]          free_idx;
    logic [IDX_W-1:0]          sel_idx;
    logic                      sel_vld;
    logic                      enq_fire;
    logic [TAG_W-1:0]          src_tag;

    assign enq_ready   = (count_q < CNT_W'(DEPTH));
    assign enq_fire    = enq_valid && enq_ready && !STALL && !FLUSH;
    assign count       = count_q;
    assign iss_valid   = iss_valid_q;
    assign iss_payload = iss_payload_q;
    assign iss_val     = iss_val_q;
    assign iss_seq     = iss_seq_q;

    // Downward scan leaves the lowest-index free slot.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!vld_q[i]) free_idx = IDX_W'(i);
        end
    end

`ifdef ISSUE_OLDEST_FIRST_EN
    logic [SEQ_W-1:0] age, best_age;
    // Age relative to the ROB head handles sequence-number wrap; strict '<' keeps the lowest index on ties.
    always_comb begin
        sel_vld  = 1'b0;
        sel_idx  = '0;
        best_age = '0;
        age      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age = seq_q[i] - head_seq;
            if (vld_q[i] && (&rdy_q[i]) && (!sel_vld || age < best_age)) begin
                sel_vld  = 1'b1;
                sel_idx  = IDX_W'(i);
                best_age = age;
            end
        end
    end
`else
    logic unused_head_seq;
    assign unused_head_seq = ^head_seq;
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (&rdy_q[i]) && !sel_vld) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        vld_d         = vld_q;
        rdy_d         = rdy_q;
        tag_d         = tag_q;
        val_d         = val_q;
        seq_d         = seq_q;
        pay_d         = pay_q;
        count_d       = count_q;
        iss_valid_d   = iss_valid_q;
        iss_payload_d = iss_payload_q;
        iss_val_d     = iss_val_q;
        iss_seq_d     = iss_seq_q;
        src_tag       = '0;

        // Wakeup runs regardless of STALL; already-ready sources keep their value.
        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < NSRC; s++) begin
                if (bc_valid && bc_tag != '0 && vld_q[i] && !rdy_q[i][s] &&
                    tag_q[i][s*TAG_W +: TAG_W] == bc_tag) begin
                    rdy_d[i][s]                 = 1'b1;
                    val_d[i][s*DATA_W +: DATA_W] = bc_val;
                end
            end
        end

        if (FLUSH) begin
            vld_d         = '0;
            for (int i = 0; i < DEPTH; i++) rdy_d[i] = '0;
            count_d       = '0;
            iss_valid_d   = 1'b0;
            iss_payload_d = '0;
            iss_val_d     = '0;
            iss_seq_d     = '0;
        end else if (!STALL) begin
            if (sel_vld) begin
                vld_d[sel_idx] = 1'b0;
                iss_valid_d    = 1'b1;
                iss_payload_d  = pay_q[sel_idx];
                iss_val_d      = val_q[sel_idx];
                iss_seq_d      = seq_q[sel_idx];
            end else begin
                iss_valid_d   = 1'b0;
                iss_payload_d = '0;
                iss_val_d     = '0;
                iss_seq_d     = '0;
            end

            // The free slot comes from registered state, so it can never be the slot being issued.
            if (enq_fire) begin
                vld_d[free_idx] = 1'b1;
                seq_d[free_idx] = enq_seq;
                pay_d[free_idx] = enq_payload;
                tag_d[free_idx] = enq_tag;
                val_d[free_idx] = enq_val;
                for (int s = 0; s < NSRC; s++) begin
                    src_tag = enq_tag[s*TAG_W +: TAG_W];
                    rdy_d[free_idx][s] = !enq_busy[s] || (src_tag == '0);
                    // Capture a result broadcast in the same cycle as the enqueue, otherwise it would be missed.
                    if (enq_busy[s] && src_tag != '0 && bc_valid && bc_tag == src_tag) begin
                        rdy_d[free_idx][s]                 = 1'b1;
                        val_d[free_idx][s*DATA_W +: DATA_W] = bc_val;
                    end
                end
            end

            case ({enq_fire, sel_vld})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            vld_q         <= '0;
            count_q       <= '0;
            iss_valid_q   <= 1'b0;
            iss_payload_q <= '0;
            iss_val_q     <= '0;
            iss_seq_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rdy_q[i] <= '0;
                tag_q[i] <= '0;
                val_q[i] <= '0;
                seq_q[i] <= '0;
                pay_q[i] <= '0;
            end
        end else begin
            vld_q         <= vld_d;
            count_q       <= count_d;
            iss_valid_q   <= iss_valid_d;
            iss_payload_q <= iss_payload_d;
            iss_val_q     <= iss_val_d;
            iss_seq_q     <= iss_seq_d;
            for (int i = 0; i < DEPTH; i++) begin
                rdy_q[i] <= rdy_d[i];
                tag_q[i] <= tag_d[i];
                val_q[i] <= val_d[i];
                seq_q[i] <= seq_d[i];
                pay_q[i] <= pay_d[i];
            end
        end
    end
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue with default parameters.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-computed per step.
module tb_issue_queue;
    localparam int DEPTH     = 16;
    localparam int NSRC      = 3;
    localparam int TAG_W     = 6;
    localparam int DATA_W    = 32;
    localparam int PAYLOAD_W = 138;
    localparam int SEQ_W     = 6;

    logic                       CLK;
    logic                       RESET;
    logic                       STALL;
    logic                       FLUSH;
    logic                       enq_valid;
    logic                       enq_ready;
    logic [SEQ_W-1:0]           enq_seq;
    logic [PAYLOAD_W-1:0]       enq_payload;
    logic [NSRC*TAG_W-1:0]      enq_tag;
    logic [NSRC-1:0]            enq_busy;
    logic [NSRC*DATA_W-1:0]     enq_val;
    logic                       bc_valid;
    logic [TAG_W-1:0]           bc_tag;
    logic [DATA_W-1:0]          bc_val;
    logic [SEQ_W-1:0]           head_seq;
    logic                       iss_valid;
    logic [PAYLOAD_W-1:0]       iss_payload;
    logic [NSRC*DATA_W-1:0]     iss_val;
    logic [SEQ_W-1:0]           iss_seq;
    logic [$clog2(DEPTH+1)-1:0] count;

    int vectors    = 0;
    int miscompares = 0;

    issue_queue #(
        .DEPTH(DEPTH), .NSRC(NSRC), .TAG_W(TAG_W), .DATA_W(DATA_W),
        .PAYLOAD_W(PAYLOAD_W), .SEQ_W(SEQ_W)
    ) dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_seq(enq_seq),
        .enq_payload(enq_payload), .enq_tag(enq_tag), .enq_busy(enq_busy),
        .enq_val(enq_val), .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_val(bc_val),
        .head_seq(head_seq), .iss_valid(iss_valid), .iss_payload(iss_payload),
        .iss_val(iss_val), .iss_seq(iss_seq), .count(count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // tags/vals packed with source 0 in the low bits
    task automatic put(input logic [5:0] s, input logic [17:0] tags, input logic [2:0] busy,
                       input logic [95:0] vals);
        enq_valid   = 1'b1;
        enq_seq     = s;
        enq_payload = PAYLOAD_W'({8'hC3, s});
        enq_tag     = tags;
        enq_busy    = busy;
        enq_val     = vals;
    endtask

    task automatic bcast(input logic v, input logic [5:0] t, input logic [31:0] d);
        bc_valid = v;
        bc_tag   = t;
        bc_val   = d;
    endtask

    initial begin
        RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
        enq_valid = 1'b0; enq_seq = '0; enq_payload = '0; enq_tag = '0; enq_busy = '0; enq_val = '0;
        bc_valid = 1'b0; bc_tag = '0; bc_val = '0; head_seq = '0;

        // reset state
        #2;
        chk("rst_count", 256'(count), 256'(0));
        chk("rst_enq_ready", 256'(enq_ready), 256'(1));
        chk("rst_iss_valid", 256'(iss_valid), 256'(0));
        @(posedge CLK);
        #1 RESET = 1'b1;

        // all-ready entry (tag 0 overrides busy) issues on the next edge
        put(6'd5, {6'd0, 6'd0, 6'd0}, 3'b111, {32'd0, 32'd4, 32'd3});
        tick();
        chk("t1_count_after_enq", 256'(count), 256'(1));
        chk("t1_no_issue_yet", 256'(iss_valid), 256'(0));
        enq_valid = 1'b0;
        tick();
        chk("t1_iss_valid", 256'(iss_valid), 256'(1));
        chk("t1_iss_seq", 256'(iss_seq), 256'(5));
        chk("t1_iss_val", 256'(iss_val), 256'({32'd0, 32'd4, 32'd3}));
        chk("t1_iss_payload", 256'(iss_payload), 256'({8'hC3, 6'd5}));
        chk("t1_count_after_iss", 256'(count), 256'(0));
        tick();
        chk("t1_idle_valid", 256'(iss_valid), 256'(0));
        chk("t1_idle_val", 256'(iss_val), 256'(0));

        // wakeup by broadcast, issue one cycle after the broadcast edge
        put(6'd7, {6'd0, 6'd0, 6'd12}, 3'b001, {32'd3, 32'd2, 32'h55});
        tick();
        chk("t2_count", 256'(count), 256'(1));
        enq_valid = 1'b0;
        bcast(1'b1, 6'd12, 32'hDEAD);
        tick();
        chk("t2_no_issue_on_bc_edge", 256'(iss_valid), 256'(0));
        bcast(1'b0, 6'd0, 32'd0);
        tick();
        chk("t2_iss_valid", 256'(iss_valid), 256'(1));
        chk("t2_iss_seq", 256'(iss_seq), 256'(7));
        chk("t2_iss_val", 256'(iss_val), 256'({32'd3, 32'd2, 32'hDEAD}));
        chk("t2_count", 256'(count), 256'(0));

        // fill all 16 slots with waiting entries
        for (int i = 0; i < 16; i++) begin
            put(6'(i), {6'd0, 6'd0, 6'(16 + i)}, 3'b001, {32'd0, 32'(i), 32'd0});
            tick();
        end
        chk("t3_count_full", 256'(count), 256'(16));
        chk("t3_enq_ready_full", 256'(enq_ready), 256'(0));
        put(6'd40, {6'd0, 6'd0, 6'd0}, 3'b000, 96'd0);
        tick();
        chk("t3_17th_rejected", 256'(count), 256'(16));
        enq_valid = 1'b0;
        bcast(1'b1, 6'd16, 32'h100);
        tick();
        chk("t3_count_bc_edge", 256'(count), 256'(16));
        bcast(1'b0, 6'd0, 32'd0);
        tick();
        chk("t3_iss_seq0", 256'(iss_seq), 256'(0));
        chk("t3_iss_val0", 256'(iss_val), 256'({32'd0, 32'd0, 32'h100}));
        chk("t3_count_15", 256'(count), 256'(15));
        chk("t3_enq_ready_back", 256'(enq_ready), 256'(1));

        // STALL: wakeup still captured, outputs held, then issue after release
        STALL = 1'b1;
        bcast(1'b1, 6'd17, 32'hBEEF);
        tick();
        chk("t4_hold_valid", 256'(iss_valid), 256'(1));
        chk("t4_hold_seq", 256'(iss_seq), 256'(0));
        chk("t4_hold_count", 256'(count), 256'(15));
        bcast(1'b0, 6'd0, 32'd0);
        tick();
        chk("t4_hold_seq2", 256'(iss_seq), 256'(0));
        STALL = 1'b0;
        tick();
        chk("t4_iss_seq1", 256'(iss_seq), 256'(1));
        chk("t4_iss_val1", 256'(iss_val), 256'({32'd0, 32'd1, 32'hBEEF}));
        chk("t4_count_14", 256'(count), 256'(14));

        // second broadcast to an already-ready source must not overwrite
        STALL = 1'b1;
        bcast(1'b1, 6'd18, 32'h111);
        tick();
        bcast(1'b1, 6'd18, 32'h222);
        tick();
        STALL = 1'b0;
        bcast(1'b0, 6'd0, 32'd0);
        tick();
        chk("t5_iss_seq2", 256'(iss_seq), 256'(2));
        chk("t5_first_bc_kept", 256'(iss_val), 256'({32'd0, 32'd2, 32'h111}));
        chk("t5_count_13", 256'(count), 256'(13));

        // FLUSH squashes everything
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        chk("t6_flush_count", 256'(count), 256'(0));
        chk("t6_flush_iss_valid", 256'(iss_valid), 256'(0));
        chk("t6_flush_enq_ready", 256'(enq_ready), 256'(1));
        bcast(1'b1, 6'd19, 32'd1);
        tick();
        bcast(1'b0, 6'd0, 32'd0);
        tick();
        chk("t6_no_survivor", 256'(iss_valid), 256'(0));

        // RESET mid-stream with 8 resident entries
        for (int i = 0; i < 8; i++) begin
            put(6'(20 + i), {6'd0, 6'd0, 6'(40 + i)}, 3'b001, 96'd0);
            tick();
        end
        enq_valid = 1'b0;
        chk("t7_count_8", 256'(count), 256'(8));
        bcast(1'b1, 6'd40, 32'd7);
        tick();
        bcast(1'b0, 6'd0, 32'd0);
        tick();
        chk("t7_iss_seq20", 256'(iss_seq), 256'(20));
        chk("t7_count_7", 256'(count), 256'(7));
        #2 RESET = 1'b0;
        #1;
        chk("t7_rst_count", 256'(count), 256'(0));
        chk("t7_rst_iss_valid", 256'(iss_valid), 256'(0));
        chk("t7_rst_iss_seq", 256'(iss_seq), 256'(0));
        chk("t7_rst_enq_ready", 256'(enq_ready), 256'(1));
        #1 RESET = 1'b1;
        bcast(1'b1, 6'd41, 32'd9);
        tick();
        bcast(1'b0, 6'd0, 32'd0);
        tick();
        chk("t7_discarded", 256'(iss_valid), 256'(0));
        chk("t7_count_0", 256'(count), 256'(0));

        // selection order: seq 62 in slot 0, seq 1 in slot 1, head 60
        head_seq = 6'd60;
        put(6'd62, {6'd0, 6'd0, 6'd50}, 3'b001, 96'd0);
        tick();
        put(6'd1, {6'd0, 6'd0, 6'd50}, 3'b001, 96'd0);
        tick();
        enq_valid = 1'b0;
        bcast(1'b1, 6'd50, 32'h50);
        tick();
        bcast(1'b0, 6'd0, 32'd0);
        tick();
        chk("t8_first_seq", 256'(iss_seq), 256'(62));
        chk("t8_count_1", 256'(count), 256'(1));
        tick();
        chk("t8_second_seq", 256'(iss_seq), 256'(1));

        // swapped slots: seq 1 in slot 0, seq 62 in slot 1
        put(6'd1, {6'd0, 6'd0, 6'd51}, 3'b001, 96'd0);
        tick();
        put(6'd62, {6'd0, 6'd0, 6'd51}, 3'b001, 96'd0);
        tick();
        enq_valid = 1'b0;
        bcast(1'b1, 6'd51, 32'h51);
        tick();
        bcast(1'b0, 6'd0, 32'd0);
        tick();
`ifdef ISSUE_OLDEST_FIRST_EN
        chk("t9_first_seq", 256'(iss_seq), 256'(62));
`else
        chk("t9_first_seq", 256'(iss_seq), 256'(1));
`endif
        // enqueue alongside the second issue: count unchanged
        put(6'd9, {6'd0, 6'd0, 6'd60}, 3'b001, 96'd0);
        tick();
`ifdef ISSUE_OLDEST_FIRST_EN
        chk("t9_second_seq", 256'(iss_seq), 256'(1));
`else
        chk("t9_second_seq", 256'(iss_seq), 256'(62));
`endif
        chk("t9_count_enq_iss", 256'(count), 256'(1));
        enq_valid = 1'b0;
        tick();
        chk("t9_waiting_no_issue", 256'(iss_valid), 256'(0));
        chk("t9_count_final", 256'(count), 256'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
